mem_access_sequencer: RTL

//  Drives the single shared 16-bit memory port for the Tron CPU.

---
 rtl/mem_access_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Owns the single shared memory port of the Tron CPU. It alternates
//   instruction fetches (address from the PC) with execute-phase load/store
//   accesses, runs the mem_en/mem_ready handshake and guards every access
//   with a watchdog that parks the block in a sticky FAULT state.
//
// Ports
//   clk_i          rising-edge system clock
//   reset_n_i      asynchronous active-low reset
//   pc_i           current program counter (fetch address)
//   pc_en_o        1-cycle pulse when a fetch completes (advance PC)
//   ls_req_i       load/store request, sampled while executing
//   ls_we_i        1 = store, 0 = load (sampled with ls_req_i)
//   ls_addr_i      load/store address
//   ls_wdata_i     store data
//   exec_done_i    non-memory instruction finished executing
//   mem_en_o       memory access request
//   mem_we_o       memory write enable
//   mem_addr_o     memory address
//   mem_wdata_o    memory write data (0 for loads and fetches)
//   mem_ready_i    memory completed the current access this cycle
//   fetch_phase_o  1 while the memory data is an instruction
//   load_valid_o   1-cycle pulse when load data on the bus is valid
//   fault_o        sticky: an access timed out
module mem_access_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic                  pc_en_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  input  logic                  exec_done_i,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  output logic                  fetch_phase_o,
  output logic                  load_valid_o,
  output logic                  fault_o
);

  // A zero TIMEOUT disables the watchdog; the counter still needs one bit.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_TERM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_FAULT
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  timeout_hit;
  logic [CW-1:0]         cnt_inc;

  // The terminal wait cycle only faults when mem_ready is absent; a ready on
  // that same cycle is handled first in the FSM and completes the access.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_TERM);
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    pc_en_o       = 1'b0;
    mem_en_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    fetch_phase_o = 1'b0;
    load_valid_o  = 1'b0;
    fault_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_en_o      = 1'b1;
        mem_addr_o    = pc_i;
        fetch_phase_o = 1'b1;
        if (mem_ready_i) begin
          pc_en_o = 1'b1;
          state_d = S_EXEC;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // ls_req has priority over exec_done when both arrive together.
      S_EXEC: begin
        if (ls_req_i) begin
          we_d    = ls_we_i;
          addr_d  = ls_addr_i;
          wdata_d = ls_wdata_i;
          cnt_d   = '0;
          state_d = S_MEM;
        end else if (exec_done_i) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end

      // Latched values keep address/data stable even if the datapath moves on.
      S_MEM: begin
        mem_en_o    = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = we_q ? wdata_q : '0;
        if (mem_ready_i) begin
          load_valid_o = ~we_q;
          cnt_d        = '0;
          state_d      = S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_FAULT: begin
        fault_o = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
